// File: rtl/clock_set_controller.sv
// Front-panel time-set controller: button conditioning, edit FSM with shadow
// hour/minute registers, commit strobe, edit timeout and field blink.
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int BLINK_CYCLES    = 12500000,
    parameter int TIMEOUT_TICKS   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic       blank_hour,
    output logic       blank_min,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BL_W    = $clog2(BLINK_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
    localparam logic [BL_W-1:0]  BLINK_LAST  = BL_W'(BLINK_CYCLES - 1);
    localparam logic [BL_W-1:0]  BL_ONE      = BL_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TO_W-1:0]  TO_ONE      = TO_W'(1);

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0]      sync1_r, sync2_r, level_r, level_d_r;
    logic [DB_W-1:0] db_cnt_r [2];
    logic [1:0]      press_s;

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_phase_r;
    logic             rep_evt_s;
    logic             mode_evt_s, inc_evt_s;

    state_t          state_r, state_nxt_s;
    logic [4:0]      shadow_hour_r, shadow_hour_nxt_s;
    logic [5:0]      shadow_min_r, shadow_min_nxt_s;
    logic [TO_W-1:0] tick_cnt_r, tick_cnt_nxt_s;
    logic [BL_W-1:0] blink_cnt_r, blink_cnt_nxt_s;
    logic            phase_r, phase_nxt_s;
    logic            in_set_nxt_s;

    assign press_s    = level_r & ~level_d_r;
    assign mode_evt_s = press_s[0];
    assign inc_evt_s  = (press_s[1] | rep_evt_s) & ~press_s[0];
    assign state      = state_r;

    // Two-flop synchronizers followed by stable-count debouncers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r     <= 2'b00;
            sync2_r     <= 2'b00;
            level_r     <= 2'b00;
            level_d_r   <= 2'b00;
            db_cnt_r[0] <= '0;
            db_cnt_r[1] <= '0;
        end else begin
            sync1_r   <= {btn_inc, btn_mode};
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != level_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        level_r[i]  <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Auto-repeat event: first after the hold delay, then at the repeat rate.
    always_comb begin
        rep_evt_s = 1'b0;
        if (level_r[1] && !press_s[1]) begin
            rep_evt_s = rep_phase_r ? (rep_cnt_r == REPEAT_LAST) : (rep_cnt_r == HOLD_LAST);
        end else begin
            rep_evt_s = 1'b0;
        end
    end

    // Auto-repeat interval counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt_r   <= '0;
            rep_phase_r <= 1'b0;
        end else if (press_s[1] || !level_r[1]) begin
            rep_cnt_r   <= '0;
            rep_phase_r <= 1'b0;
        end else if (rep_evt_s) begin
            rep_cnt_r   <= '0;
            rep_phase_r <= 1'b1;
        end else begin
            rep_cnt_r <= rep_cnt_r + REP_ONE;
        end
    end

    // Edit FSM next state, shadow updates, timeout and blink phase.
    always_comb begin
        state_nxt_s       = state_r;
        shadow_hour_nxt_s = shadow_hour_r;
        shadow_min_nxt_s  = shadow_min_r;
        tick_cnt_nxt_s    = tick_1hz ? (tick_cnt_r + TO_ONE) : tick_cnt_r;
        phase_nxt_s       = phase_r;
        blink_cnt_nxt_s   = blink_cnt_r + BL_ONE;
        if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_nxt_s = '0;
            phase_nxt_s     = ~phase_r;
        end else begin
            phase_nxt_s = phase_r;
        end
        case (state_r)
            ST_RUN: begin
                if (mode_evt_s) begin
                    state_nxt_s       = ST_SET_HOUR;
                    shadow_hour_nxt_s = cur_hour;
                    shadow_min_nxt_s  = cur_min;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SET_HOUR: begin
                if (mode_evt_s) begin
                    state_nxt_s = ST_SET_MIN;
                end else if (inc_evt_s) begin
                    shadow_hour_nxt_s = (shadow_hour_r == 5'd23) ? 5'd0 : shadow_hour_r + 5'd1;
                end else if (tick_1hz && (tick_cnt_r == TO_LAST)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SET_HOUR;
                end
            end
            ST_SET_MIN: begin
                if (mode_evt_s) begin
                    state_nxt_s = ST_COMMIT;
                end else if (inc_evt_s) begin
                    shadow_min_nxt_s = (shadow_min_r == 6'd59) ? 6'd0 : shadow_min_r + 6'd1;
                end else if (tick_1hz && (tick_cnt_r == TO_LAST)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SET_MIN;
                end
            end
            ST_COMMIT: state_nxt_s = ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
        in_set_nxt_s = (state_nxt_s == ST_SET_HOUR) || (state_nxt_s == ST_SET_MIN);
        // Entering an edit field or bumping it shows the field solidly again.
        if ((in_set_nxt_s && (state_nxt_s != state_r)) || inc_evt_s) begin
            phase_nxt_s     = 1'b0;
            blink_cnt_nxt_s = '0;
        end else begin
            blink_cnt_nxt_s = blink_cnt_nxt_s;
        end
        if (!in_set_nxt_s || (state_nxt_s != state_r) || mode_evt_s || inc_evt_s) begin
            tick_cnt_nxt_s = '0;
        end else begin
            tick_cnt_nxt_s = tick_cnt_nxt_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_RUN;
            shadow_hour_r <= 5'd0;
            shadow_min_r  <= 6'd0;
            tick_cnt_r    <= '0;
            blink_cnt_r   <= '0;
            phase_r       <= 1'b0;
            run_en        <= 1'b1;
            load          <= 1'b0;
            load_hour     <= 5'd0;
            load_min      <= 6'd0;
            disp_hour     <= cur_hour;
            disp_min      <= cur_min;
            blank_hour    <= 1'b0;
            blank_min     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            shadow_hour_r <= shadow_hour_nxt_s;
            shadow_min_r  <= shadow_min_nxt_s;
            tick_cnt_r    <= tick_cnt_nxt_s;
            blink_cnt_r   <= blink_cnt_nxt_s;
            phase_r       <= phase_nxt_s;
            run_en        <= (state_nxt_s == ST_RUN);
            load          <= (state_nxt_s == ST_COMMIT);
            if (state_nxt_s == ST_COMMIT) begin
                load_hour <= shadow_hour_nxt_s;
                load_min  <= shadow_min_nxt_s;
            end
            disp_hour  <= (state_nxt_s == ST_RUN) ? cur_hour : shadow_hour_nxt_s;
            disp_min   <= (state_nxt_s == ST_RUN) ? cur_min : shadow_min_nxt_s;
            blank_hour <= (state_nxt_s == ST_SET_HOUR) && phase_nxt_s;
            blank_min  <= (state_nxt_s == ST_SET_MIN) && phase_nxt_s;
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button presses
// checked against a press-level model of the edit/commit behaviour.
module tb_clock_set_controller;

    localparam int DB = 4, HOLD = 20, REP = 5, BLINK = 8, TMO = 3;

    logic       clk, reset, btn_mode, btn_inc, tick_1hz;
    logic [4:0] cur_hour, load_hour, disp_hour;
    logic [5:0] cur_min, load_min, disp_min;
    logic       run_en, load, blank_hour, blank_min;
    logic [1:0] state;

    int checks = 0, errors = 0;
    int exp_state = 0, sh = 0, sm = 0, exp_loads = 0, exp_lh = 0, exp_lm = 0;
    int load_pulses = 0, load_long = 0, last_lh = 0, last_lm = 0;
    logic load_prev = 1'b0;

    clock_set_controller #(
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .BLINK_CYCLES(BLINK), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .tick_1hz(tick_1hz), .cur_hour(cur_hour), .cur_min(cur_min),
        .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
        .disp_hour(disp_hour), .disp_min(disp_min), .blank_hour(blank_hour),
        .blank_min(blank_min), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load strobe monitor: counts pulses and flags any pulse wider than one cycle.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_pulses++;
            last_lh = int'(load_hour);
            last_lm = int'(load_min);
            if (load_prev === 1'b1) load_long++;
        end
        load_prev = load;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Number of increments produced by a clean press held for len cycles.
    function automatic int inc_events(input int len);
        if (len < DB) return 0;
        if (len - 1 < HOLD) return 1;
        return 2 + (len - 1 - HOLD) / REP;
    endfunction

    task automatic model_mode();
        case (exp_state)
            0: begin exp_state = 1; sh = int'(cur_hour); sm = int'(cur_min); end
            1: exp_state = 2;
            2: begin exp_state = 0; exp_loads++; exp_lh = sh; exp_lm = sm; end
            default: exp_state = 0;
        endcase
    endtask

    task automatic model_inc(input int n);
        if (exp_state == 1) sh = (sh + n) % 24;
        else if (exp_state == 2) sm = (sm + n) % 60;
    endtask

    task automatic press(input bit m, input bit i, input int len);
        btn_mode = m;
        btn_inc  = i;
        step(len);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(12);
    endtask

    task automatic check_view(input string tag);
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".run_en"}, 32'(run_en), 32'(exp_state == 0));
        check({tag, ".disp_hour"}, 32'(disp_hour), 32'(exp_state == 0 ? int'(cur_hour) : sh));
        check({tag, ".disp_min"}, 32'(disp_min), 32'(exp_state == 0 ? int'(cur_min) : sm));
        check({tag, ".loads"}, 32'(load_pulses), 32'(exp_loads));
    endtask

    initial begin
        int ones, len, prev;
        bit found;
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
        cur_hour = 5'd13; cur_min = 6'd45;
        step(3);
        reset = 1'b1;
        step(2);
        check_view("reset");
        check("reset.load", 32'(load), 32'd0);
        check("reset.blank_hour", 32'(blank_hour), 32'd0);
        check("reset.blank_min", 32'(blank_min), 32'd0);
        check("reset.load_hour", 32'(load_hour), 32'd0);

        // Enter SET_HOUR and walk the hour through its wrap.
        press(1'b1, 1'b0, 10); model_mode();
        check_view("enter_hour");
        for (int k = 0; k < 11; k++) begin
            press(1'b0, 1'b1, 6); model_inc(inc_events(6));
            check("hour_step", 32'(disp_hour), 32'(sh));
        end
        check("hour_wrapped", 32'(disp_hour), 32'd0);
        press(1'b0, 1'b1, 121); model_inc(inc_events(121));
        check("hour_autorep", 32'(disp_hour), 32'd22);

        // Minutes wrap, then commit.
        press(1'b1, 1'b0, 8); model_mode();
        for (int k = 0; k < 15; k++) press(1'b0, 1'b1, 6);
        model_inc(15);
        check("min_wrapped", 32'(disp_min), 32'd0);
        press(1'b1, 1'b0, 8); model_mode();
        check_view("commit1");
        check("commit1.lh", 32'(last_lh), 32'd22);
        check("commit1.lm", 32'(last_lm), 32'd0);

        // Bounces ignored; a 40-cycle hold gives press + hold + three repeats.
        press(1'b1, 1'b0, 8); model_mode();
        press(1'b1, 1'b0, 8); model_mode();
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 3);
        check("bounce", 32'(disp_min), 32'(sm));
        press(1'b0, 1'b1, 40); model_inc(inc_events(40));
        check("hold40", 32'(disp_min), 32'd50);
        press(1'b1, 1'b0, 8); model_mode();
        check_view("commit2");
        check("commit2.lm", 32'(last_lm), 32'd50);

        // Blink phase starts visible on entry.
        btn_mode = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (k == 7) btn_mode = 1'b0;
            if (state == 2'd1) found = 1'b1;
        end
        btn_mode = 1'b0;
        check("blink.entry_seen", 32'(found), 32'd1);
        model_mode();
        check("blink.first", 32'(blank_hour), 32'd0);
        ones = 0;
        for (int k = 0; k < 2 * BLINK; k++) begin
            if (k > 0) step(1);
            if (blank_hour === 1'b1) ones++;
        end
        check("blink.ones", 32'(ones), 32'(BLINK));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (blank_hour === 1'b1) found = 1'b1;
        end
        check("blink.high_seen", 32'(found), 32'd1);

        // An inc event forces the field visible.
        prev = int'(disp_hour);
        btn_inc = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (k == 5) btn_inc = 1'b0;
            if (int'(disp_hour) != prev) found = 1'b1;
        end
        btn_inc = 1'b0;
        check("inc_blink.seen", 32'(found), 32'd1);
        check("inc_blink.blank", 32'(blank_hour), 32'd0);
        model_inc(1);
        step(12);

        // Edit timeout after TMO ticks, no load issued.
        for (int t = 0; t < TMO; t++) begin
            tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(3);
            if (t == TMO - 2) check("timeout.before", 32'(state), 32'd1);
        end
        exp_state = 0;
        check_view("timeout");

        // Mode and inc together: mode wins, shadow untouched.
        press(1'b1, 1'b0, 8); model_mode();
        press(1'b0, 1'b1, 6); model_inc(1);
        press(1'b1, 1'b1, 6); model_mode();
        check_view("both");
        press(1'b1, 1'b0, 8); model_mode();
        check_view("both_commit");
        check("both.lh", 32'(last_lh), 32'(exp_lh));

        // Reset mid-edit.
        cur_hour = 5'd7; cur_min = 6'd30;
        press(1'b1, 1'b0, 8); model_mode();
        press(1'b1, 1'b0, 8); model_mode();
        check_view("pre_reset");
        reset = 1'b0; step(1);
        check("rst.state", 32'(state), 32'd0);
        check("rst.run_en", 32'(run_en), 32'd1);
        check("rst.load", 32'(load), 32'd0);
        reset = 1'b1; step(5);
        exp_state = 0;
        check_view("post_reset");

        // Random presses against the model.
        for (int n = 0; n < 60; n++) begin
            if (exp_state == 0) begin
                cur_hour = 5'($urandom_range(0, 23));
                cur_min  = 6'($urandom_range(0, 59));
            end
            if ($urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, 12);
                press(1'b1, 1'b0, len);
                if (inc_events(len) > 0) model_mode();
            end else begin
                len = $urandom_range(1, 60);
                press(1'b0, 1'b1, len);
                model_inc(inc_events(len));
            end
            check_view("rand");
            check("rand.lh", 32'(last_lh), 32'(exp_lh));
            check("rand.lm", 32'(last_lm), 32'(exp_lm));
        end

        check("load_width", 32'(load_long), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
